// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and
// counter sizing. Legal WIDTH range is 2..32.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned SA_WIDTH_MIN = 2;
  localparam int unsigned SA_WIDTH_MAX = 32;

  // Bit-index counter must hold 0..width-1; never narrower than one bit.
  function automatic int unsigned sa_cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational single-bit full adder used as the serial bit slice.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_axb;

  assign w_axb  = i_a ^ i_b;
  assign o_s    = w_axb ^ i_cin;
  assign o_cout = (i_a & i_b) | (w_axb & i_cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through one fa_cell.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned   CW       = sa_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_load;
  logic             w_bit;
  logic             w_carry_nxt;
  logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1: invert B at capture and seed the carry with 1.
  assign w_b_load     = sub ? ~b : b;
  assign w_carry_load = sub ? 1'b1 : cin;
`else
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_b_load     = b;
  assign w_carry_load = cin;
`endif

  fa_cell u_fa (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_cin  (r_carry),
    .o_s    (w_bit),
    .o_cout (w_carry_nxt)
  );

  assign w_last = (r_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_load;
            r_carry <= w_carry_load;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // New bit enters at the MSB so after WIDTH shifts bit 0 lands at sum[0].
          r_sum   <= {w_bit, r_sum[WIDTH-1:1]};
          r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_carry <= w_carry_nxt;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout  <= w_carry_nxt;
            r_ovf   <= r_carry ^ w_carry_nxt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results computed
// arithmetically; a negedge monitor pops and compares on every done pulse.
module tb_serial_adder;

  localparam int unsigned W    = 8;
  localparam longint      MODV = 64'sd1 << W;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int unsigned  due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  exp_t        exp_q[$];
  exp_t        last_exp;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  logic        prev_done = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic icin, input logic isub);
    exp_t   r;
    longint ua, ub, sa, sb, tot, st, modded;
    logic   do_sub;
`ifdef SERIAL_ADDER_SUB_EN
    do_sub = isub;
`else
    do_sub = isub & 1'b0;
`endif
    ua = longint'(ia);
    ub = longint'(ib);
    sa = ia[W-1] ? ua - MODV : ua;
    sb = ib[W-1] ? ub - MODV : ub;
    if (do_sub) begin
      tot    = ua - ub;
      st     = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      tot    = ua + ub + longint'(icin);
      st     = sa + sb + longint'(icin);
      r.cout = (tot >= MODV);
    end
    modded = (tot + MODV) % MODV;
    r.sum  = modded[W-1:0];
    r.ovf  = (st > MODV / 2 - 1) || (st < -(MODV / 2));
    r.due  = 0;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      chk("done_one_cycle", prev_done, 0);
      chk("busy_in_done", busy, 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sum", sum, e.sum);
        chk("cout", cout, e.cout);
        chk("ovf", ovf, e.ovf);
        chk("latency", cyc, e.due);
      end
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request now; it is accepted at the next edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub);
    exp_t e;
    chk("idle_before_start", busy, 0);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    e = model(ia, ib, icin, isub);
    tick();
    e.due = cyc + W;
    exp_q.push_back(e);
    last_exp = e;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  // Wait for idle; optionally pulse start with junk operands while busy.
  task automatic wait_idle(input bit junk);
    for (int i = 0; i < 4 * W; i++) begin
      if (!busy) begin
        start = 1'b0;
        return;
      end
      if (junk) begin
        start = 1'($urandom_range(0, 2) == 0);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      tick();
    end
    start = 1'b0;
    chk("wait_idle_timeout", busy, 0);
  endtask

  task automatic check_held();
    chk("held_sum", sum, last_exp.sum);
    chk("held_cout", cout, last_exp.cout);
    chk("held_ovf", ovf, last_exp.ovf);
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, input logic isub);
    issue(ia, ib, icin, isub);
    wait_idle(1'b0);
    check_held();
    tick();
    check_held();
  endtask

  initial begin
    exp_t first;
    bit   seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h7F, 8'h00, 1'b1, 1'b0);

    // Starts during RUN cycles 3 and W and during DONE must be ignored.
    issue(8'h12, 8'h34, 1'b1, 1'b0);
    for (int k = 1; k <= W; k++) begin
      start = (k == 3 || k == W);
      a = 8'hEE; b = 8'hDD; cin = 1'b0;
      chk("busy_run", busy, 1);
      tick();
    end
    start = 1'b1;
    chk("busy_done_cycle", busy, 1);
    tick();
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);
    repeat (W + 3) tick();
    check_held();

    // Reset on RUN cycle 4 aborts with no done pulse.
    issue(8'hA5, 8'h5A, 1'b1, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_ovf", ovf, 0);
    repeat (W + 3) tick();
    run_op(8'h33, 8'h44, 1'b0, 1'b0);

    run_op(8'h10, 8'h20, 1'b0, 1'b1);

    // Back-to-back: restart in the idle cycle right after done.
    issue(8'h80, 8'h80, 1'b0, 1'b0);
    first = last_exp;
    seen  = 1'b0;
    for (int i = 0; i < 4 * W && !seen; i++) begin
      tick();
      seen = done;
    end
    chk("b2b_done_seen", seen, 1);
    tick();
    chk("b2b_idle", busy, 0);
    chk("b2b_held_sum", sum, first.sum);
    issue(8'h01, 8'h02, 1'b0, 1'b0);
    chk("b2b_held_cout_run", cout, first.cout);
    chk("b2b_held_ovf_run", ovf, first.ovf);
    wait_idle(1'b0);
    check_held();

    for (int n = 0; n < 40; n++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      wait_idle(1'b1);
      check_held();
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (4) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
